// File: rtl/writeback_commit_pkg.sv
// writeback_commit_pkg
//   Shared types and helpers for the multi-lane writeback/commit stage.
//   WB_ENTRY  : one MEM result as it enters the commit queue.
//   WB_COMMIT : one retired instruction as reported to the difftest side.
//   WB_QDEPTH_DEFAULT : default number of commit queue entries.
//   Helper functions give the writeback value, the effective write flag and
//   the "this entry ends the commit group" condition.
package writeback_commit_pkg;

  localparam int WB_QDEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [63:0] instrAddr;
    logic [31:0] instr;
    logic [4:0]  wd;
    logic [63:0] aluOut;
    logic [63:0] memOut;
    logic [63:0] pcPlus4;
    logic        isWriteBack;
    logic        isMemRead;
    logic        isJump;
    logic        isBranch;
    logic        branchAdopted;
  } WB_ENTRY;

  typedef struct packed {
    logic        valid;
    logic        isWb;
    logic [4:0]  wd;
    logic [63:0] wdData;
    logic [63:0] instrAddr;
    logic [31:0] instr;
  } WB_COMMIT;

  // Loads write the memory value, jumps write the link address, everything
  // else writes the ALU result.
  function automatic logic [63:0] wbResult(input WB_ENTRY e);
    if (e.isMemRead) return e.memOut;
    if (e.isJump)    return e.pcPlus4;
    return e.aluOut;
  endfunction

  // Jumps always write their link register even if the decoder did not flag
  // a writeback.
  function automatic logic wbIsWb(input WB_ENTRY e);
    return e.isWriteBack | e.isJump;
  endfunction

  // A jump or a taken branch redirects fetch, so nothing younger may retire
  // alongside it.
  function automatic logic wbEndsGroup(input WB_ENTRY e);
    return e.isJump | (e.isBranch & e.branchAdopted);
  endfunction

endpackage

// File: rtl/wb_commit_queue.sv
// wb_commit_queue
//   Circular in-order commit queue with multi-push, multi-pop and flush.
//   Optional macro: WB_FWD_EN exposes the raw storage and head pointer so the
//   top level can run a bypass lookup over the queued entries.
// Ports
//   clk, rst      : clock, synchronous active-high reset (empties the queue)
//   i_flush       : drop every queued entry; has priority over push/pop
//   i_pushN       : number of lanes of i_pushEntry to append at the tail
//   i_pushEntry   : entries to append, lane 0 first
//   i_popN        : number of entries to remove from the head
//   o_headEntry   : the LANES oldest storage slots starting at head
//   o_entries     : [WB_FWD_EN] raw storage
//   o_head        : [WB_FWD_EN] head pointer
//   o_count       : number of valid entries
module wb_commit_queue
  import writeback_commit_pkg::*;
#(
  parameter int  LANES  = 2,
  parameter int  QDEPTH = WB_QDEPTH_DEFAULT,
  localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic [CW-1:0]            i_pushN,
  input  WB_ENTRY [LANES-1:0]      i_pushEntry,
  input  logic [CW-1:0]            i_popN,
  output WB_ENTRY [LANES-1:0]      o_headEntry,
`ifdef WB_FWD_EN
  output WB_ENTRY [QDEPTH-1:0]     o_entries,
  output logic [PW-1:0]            o_head,
`endif
  output logic [CW-1:0]            o_count
);

  WB_ENTRY [QDEPTH-1:0] r_mem;
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;

  // Pointer arithmetic modulo the queue depth; works for any depth,
  // including the degenerate single-entry queue.
  function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int offs);
    return PW'((int'(base) + offs) % QDEPTH);
  endfunction

  // Storage and pointers. A flush only resets the bookkeeping; the stale
  // slot contents are unreachable once count is zero. Push and pop move
  // their own pointers, and count absorbs both in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (i < int'(i_pushN)) begin
          r_mem[wrapIdx(r_tail, i)] <= i_pushEntry[i];
        end
      end
      r_tail  <= wrapIdx(r_tail, int'(i_pushN));
      r_head  <= wrapIdx(r_head, int'(i_popN));
      r_count <= r_count + i_pushN - i_popN;
    end
  end

  // Present the oldest LANES slots in age order; the consumer qualifies
  // them against o_count.
  always_comb begin
    o_headEntry = '0;
    for (int i = 0; i < LANES; i++) begin
      o_headEntry[i] = r_mem[wrapIdx(r_head, i)];
    end
  end

  assign o_count = r_count;
`ifdef WB_FWD_EN
  assign o_entries = r_mem;
  assign o_head    = r_head;
`endif

endmodule

// File: rtl/writeback_commit.sv
// writeback_commit
//   Multi-lane writeback/commit stage between MEM and the regfile/difftest.
//   MEM groups are queued in order; up to LANES entries retire per cycle, a
//   jump or taken branch ends the group, redirects fetch and squashes all
//   younger queued work.
//   Optional macro: WB_FWD_EN adds the fwd_* bypass lookup ports.
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   in_valid       : contiguous lane valids, lane 0 oldest
//   in_entry       : per-lane MEM result
//   in_ready       : room for a full LANES group (registered count only)
//   commit_ready   : downstream takes commit records this cycle
//   rf_we/wa/wd    : regfile write ports, valid for one cycle after a pop
//   commit         : per-lane commit records
//   redirect_en    : one-cycle redirect pulse
//   redirect_addr  : redirect target with bit 0 cleared
//   fwd_rs         : [WB_FWD_EN] two bypass lookup registers
//   fwd_hit        : [WB_FWD_EN] lookup found a queued writer
//   fwd_data       : [WB_FWD_EN] value of the youngest queued writer
//   instret        : retired instruction counter
module writeback_commit
  import writeback_commit_pkg::*;
#(
  parameter int  LANES  = 2,
  parameter int  QDEPTH = WB_QDEPTH_DEFAULT,
  parameter int  XLEN   = 64,
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES-1:0]            in_valid,
  input  WB_ENTRY [LANES-1:0]         in_entry,
  output logic                        in_ready,
  input  logic                        commit_ready,
  output logic [LANES-1:0]            rf_we,
  output logic [LANES-1:0][4:0]       rf_wa,
  output logic [LANES-1:0][XLEN-1:0]  rf_wd,
  output WB_COMMIT [LANES-1:0]        commit,
  output logic                        redirect_en,
  output logic [XLEN-1:0]             redirect_addr,
`ifdef WB_FWD_EN
  input  logic [1:0][4:0]             fwd_rs,
  output logic [1:0]                  fwd_hit,
  output logic [1:0][XLEN-1:0]        fwd_data,
`endif
  output logic [63:0]                 instret
);

`ifdef WB_FWD_EN
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  WB_ENTRY [QDEPTH-1:0] w_entries;
  logic [PW-1:0]        w_head;
  WB_ENTRY              w_fwdEnt;
  logic [63:0]          w_fwdRes;
`endif

  WB_ENTRY [LANES-1:0]        w_headEntry;
  logic [CW-1:0]              w_count;
  logic [CW-1:0]              w_pushN;
  logic [CW-1:0]              w_qPushN;
  logic [CW-1:0]              w_selN;
  logic [LANES-1:0]           w_validInc;
  logic                       w_run;
  logic                       w_fire;
  logic                       w_stop;
  logic                       w_redirect;
  logic [XLEN-1:0]            w_redirectAddr;
  logic [LANES-1:0][63:0]     w_result;
  logic [LANES-1:0]           w_rfWe;
  logic [LANES-1:0][4:0]      w_rfWa;
  logic [LANES-1:0][XLEN-1:0] w_rfWd;
  WB_COMMIT [LANES-1:0]       w_commit;

  logic [LANES-1:0]           r_rfWe;
  logic [LANES-1:0][4:0]      r_rfWa;
  logic [LANES-1:0][XLEN-1:0] r_rfWd;
  WB_COMMIT [LANES-1:0]       r_commit;
  logic                       r_redirectEn;
  logic [XLEN-1:0]            r_redirectAddr;
  logic [63:0]                r_instret;

  // Only a full group's worth of free slots opens the input; pops in the
  // same cycle are deliberately not credited so in_ready stays a flop output.
  assign in_ready   = (QDEPTH - int'(w_count)) >= LANES;
  assign w_validInc = in_valid + LANES'(1);

  // Count the contiguous run of valid lanes from lane 0; anything above a
  // hole is ignored. A group landing on a redirect edge is younger than the
  // redirecting instruction and is dropped.
  always_comb begin
    w_pushN = '0;
    w_run   = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (w_run && in_valid[i]) begin
        w_pushN = CW'(i + 1);
      end else begin
        w_run = 1'b0;
      end
    end
    w_qPushN = ((|in_valid) && in_ready && !w_redirect) ? w_pushN : '0;
  end

  // Build the commit set from the head: oldest first, at most LANES and at
  // most count entries, ending with the first redirecting instruction.
  always_comb begin
    w_fire         = commit_ready && (w_count != '0);
    w_selN         = '0;
    w_stop         = 1'b0;
    w_redirect     = 1'b0;
    w_redirectAddr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_fire && !w_stop && (i < int'(w_count))) begin
        w_selN = CW'(i + 1);
        if (wbEndsGroup(w_headEntry[i])) begin
          w_stop         = 1'b1;
          w_redirect     = 1'b1;
          w_redirectAddr = {w_headEntry[i].aluOut[XLEN-1:1], 1'b0};
        end
      end
    end
  end

  // Shape the per-lane regfile writes and commit records. Writes to x0 still
  // retire but neither touch the regfile nor report a writeback.
  always_comb begin
    w_result = '0;
    w_rfWe   = '0;
    w_rfWa   = '0;
    w_rfWd   = '0;
    w_commit = '0;
    for (int i = 0; i < LANES; i++) begin
      w_result[i] = wbResult(w_headEntry[i]);
      if (i < int'(w_selN)) begin
        w_rfWe[i]             = wbIsWb(w_headEntry[i]) && (w_headEntry[i].wd != 5'd0);
        w_rfWa[i]             = w_headEntry[i].wd;
        w_rfWd[i]             = w_result[i][XLEN-1:0];
        w_commit[i].valid     = 1'b1;
        w_commit[i].isWb      = wbIsWb(w_headEntry[i]) && (w_headEntry[i].wd != 5'd0);
        w_commit[i].wd        = w_headEntry[i].wd;
        w_commit[i].wdData    = w_result[i];
        w_commit[i].instrAddr = w_headEntry[i].instrAddr;
        w_commit[i].instr     = w_headEntry[i].instr;
      end
    end
  end

  // Register the retire outputs so they are visible for exactly one cycle
  // after the pop edge, and accumulate the retired count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rfWe         <= '0;
      r_rfWa         <= '0;
      r_rfWd         <= '0;
      r_commit       <= '0;
      r_redirectEn   <= 1'b0;
      r_redirectAddr <= '0;
      r_instret      <= '0;
    end else begin
      r_rfWe         <= w_rfWe;
      r_rfWa         <= w_rfWa;
      r_rfWd         <= w_rfWd;
      r_commit       <= w_commit;
      r_redirectEn   <= w_redirect;
      r_redirectAddr <= w_redirectAddr;
      r_instret      <= r_instret + 64'(w_selN);
    end
  end

  // MEM must pack valid lanes from lane 0 upward; a gap is a producer bug.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((in_valid & w_validInc) == '0);
    end
  end

  assign rf_we         = r_rfWe;
  assign rf_wa         = r_rfWa;
  assign rf_wd         = r_rfWd;
  assign commit        = r_commit;
  assign redirect_en   = r_redirectEn;
  assign redirect_addr = r_redirectAddr;
  assign instret       = r_instret;

  wb_commit_queue #(
    .LANES  (LANES),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (w_redirect),
    .i_pushN     (w_qPushN),
    .i_pushEntry (in_entry),
    .i_popN      (w_selN),
    .o_headEntry (w_headEntry),
`ifdef WB_FWD_EN
    .o_entries   (w_entries),
    .o_head      (w_head),
`endif
    .o_count     (w_count)
  );

`ifdef WB_FWD_EN
  // Bypass lookup: walk queued entries oldest to youngest so the last match
  // seen is the youngest writer of the requested register.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    w_fwdEnt = '0;
    w_fwdRes = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (i < int'(w_count)) begin
          w_fwdEnt = w_entries[PW'((int'(w_head) + i) % QDEPTH)];
          w_fwdRes = wbResult(w_fwdEnt);
          if (wbIsWb(w_fwdEnt) && (w_fwdEnt.wd == fwd_rs[k]) && (fwd_rs[k] != 5'd0)) begin
            fwd_hit[k]  = 1'b1;
            fwd_data[k] = w_fwdRes[XLEN-1:0];
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_commit.sv
// tb_writeback_commit
//   Directed self-checking bench for writeback_commit (LANES=2, QDEPTH=4).
//   Expected retire records are queued as groups are driven and popped as the
//   DUT retires them. Define WB_FWD_EN to include the bypass lookup step.
module tb_writeback_commit;
  import writeback_commit_pkg::*;

  localparam int LANES  = 2;
  localparam int QDEPTH = 4;
  localparam int XLEN   = 64;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [LANES-1:0]            in_valid;
  WB_ENTRY [LANES-1:0]         in_entry;
  logic                        in_ready;
  logic                        commit_ready;
  logic [LANES-1:0]            rf_we;
  logic [LANES-1:0][4:0]       rf_wa;
  logic [LANES-1:0][XLEN-1:0]  rf_wd;
  WB_COMMIT [LANES-1:0]        commit;
  logic                        redirect_en;
  logic [XLEN-1:0]             redirect_addr;
  logic [63:0]                 instret;
`ifdef WB_FWD_EN
  logic [1:0][4:0]             fwd_rs;
  logic [1:0]                  fwd_hit;
  logic [1:0][XLEN-1:0]        fwd_data;
`endif

  typedef struct {
    logic        rfWe;
    logic [4:0]  wa;
    logic [63:0] data;
    logic        isWb;
    logic [63:0] pc;
  } ExpRec;

  ExpRec       expQ[$];
  int          nVectors     = 0;
  int          nMiscompares = 0;
  logic [63:0] expInstret   = '0;

  always #5 clk = ~clk;

  writeback_commit #(
    .LANES  (LANES),
    .QDEPTH (QDEPTH),
    .XLEN   (XLEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_entry      (in_entry),
    .in_ready      (in_ready),
    .commit_ready  (commit_ready),
    .rf_we         (rf_we),
    .rf_wa         (rf_wa),
    .rf_wd         (rf_wd),
    .commit        (commit),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
`ifdef WB_FWD_EN
    .fwd_rs        (fwd_rs),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
`endif
    .instret       (instret)
  );

  // Advance one edge and settle just after it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [LANES-1:0] v, input WB_ENTRY e0, input WB_ENTRY e1);
    in_valid    = v;
    in_entry[0] = e0;
    in_entry[1] = e1;
  endtask

  task automatic expectRec(input logic rfWe, input logic [4:0] wa, input logic [63:0] data,
                           input logic isWb, input logic [63:0] pc);
    ExpRec r;
    r.rfWe = rfWe;
    r.wa   = wa;
    r.data = data;
    r.isWb = isWb;
    r.pc   = pc;
    expQ.push_back(r);
  endtask

  // Compare this cycle's retire outputs against the next n scoreboard
  // records; lanes beyond n must be idle. instret must follow the total.
  task automatic checkRetire(input int n);
    ExpRec r;
    for (int l = 0; l < LANES; l++) begin
      if (l < n) begin
        if (expQ.size() == 0) begin
          checkOutput($sformatf("sbUnderflow.l%0d", l), 64'(expQ.size()), 64'd1);
        end else begin
          r = expQ.pop_front();
          checkOutput($sformatf("pc%0h.valid", r.pc), 64'(commit[l].valid), 64'd1);
          checkOutput($sformatf("pc%0h.rfWe", r.pc), 64'(rf_we[l]), 64'(r.rfWe));
          checkOutput($sformatf("pc%0h.rfWa", r.pc), 64'(rf_wa[l]), 64'(r.wa));
          checkOutput($sformatf("pc%0h.rfWd", r.pc), rf_wd[l], r.data);
          checkOutput($sformatf("pc%0h.isWb", r.pc), 64'(commit[l].isWb), 64'(r.isWb));
          checkOutput($sformatf("pc%0h.wdData", r.pc), commit[l].wdData, r.data);
          checkOutput($sformatf("pc%0h.instrAddr", r.pc), commit[l].instrAddr, r.pc);
        end
      end else begin
        checkOutput($sformatf("idle.l%0d.valid", l), 64'(commit[l].valid), 64'd0);
        checkOutput($sformatf("idle.l%0d.rfWe", l), 64'(rf_we[l]), 64'd0);
      end
    end
    expInstret += 64'(n);
    checkOutput("instret", instret, expInstret);
  endtask

  function automatic WB_ENTRY mkAlu(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] val);
    WB_ENTRY e;
    e             = '0;
    e.instrAddr   = pc;
    e.instr       = 32'h0000_0013;
    e.wd          = rd;
    e.aluOut      = val;
    e.memOut      = 64'hBAD0_BAD0;
    e.pcPlus4     = pc + 64'd4;
    e.isWriteBack = 1'b1;
    return e;
  endfunction

  function automatic WB_ENTRY mkBranch(input logic [63:0] pc, input logic [63:0] target);
    WB_ENTRY e;
    e               = mkAlu(pc, 5'd0, target);
    e.isWriteBack   = 1'b0;
    e.isBranch      = 1'b1;
    e.branchAdopted = 1'b1;
    return e;
  endfunction

  initial begin
    WB_ENTRY eA;
    WB_ENTRY eB;

    rst          = 1'b1;
    commit_ready = 1'b0;
    in_valid     = '0;
    in_entry     = '0;
`ifdef WB_FWD_EN
    fwd_rs       = '0;
`endif
    tick();
    tick();

    // Reset state
    checkOutput("rst.inReady", 64'(in_ready), 64'd1);
    checkOutput("rst.redirectEn", 64'(redirect_en), 64'd0);
    checkOutput("rst.rfWd0", rf_wd[0], 64'd0);
    checkRetire(0);
    rst = 1'b0;

    // Two ADDIs in one group, retired together two edges later
    $display("[TB] step 1: dual-lane ADDI commit");
    commit_ready = 1'b1;
    applyStimulus(2'b11, mkAlu(64'h0, 5'd1, 64'd5), mkAlu(64'h4, 5'd2, 64'd7));
    expectRec(1'b1, 5'd1, 64'd5, 1'b1, 64'h0);
    expectRec(1'b1, 5'd2, 64'd7, 1'b1, 64'h4);
    tick();
    in_valid = '0;
    checkRetire(0);
    tick();
    checkRetire(2);

    // Fill the queue while stalled, then drain across the pointer wrap
    $display("[TB] step 2: fill, backpressure, drain with wrap");
    commit_ready = 1'b0;
    eB           = mkAlu(64'h14, 5'd4, 64'h1000);
    eB.isMemRead = 1'b1;
    eB.memOut    = 64'h44;
    applyStimulus(2'b11, mkAlu(64'h10, 5'd3, 64'd3), eB);
    expectRec(1'b1, 5'd3, 64'd3, 1'b1, 64'h10);
    expectRec(1'b1, 5'd4, 64'h44, 1'b1, 64'h14);
    tick();
    checkOutput("fill.halfReady", 64'(in_ready), 64'd1);
    applyStimulus(2'b11, mkAlu(64'h18, 5'd5, 64'd5), mkAlu(64'h1c, 5'd6, 64'd6));
    expectRec(1'b1, 5'd5, 64'd5, 1'b1, 64'h18);
    expectRec(1'b1, 5'd6, 64'd6, 1'b1, 64'h1c);
    tick();
    checkOutput("fill.fullReady", 64'(in_ready), 64'd0);
    checkRetire(0);
    applyStimulus(2'b11, mkAlu(64'h20, 5'd7, 64'd7), mkAlu(64'h24, 5'd8, 64'd8));
    tick();
    checkOutput("fill.heldReady", 64'(in_ready), 64'd0);
    checkRetire(0);
    commit_ready = 1'b1;
    tick();
    checkRetire(2);
    checkOutput("drain.reReady", 64'(in_ready), 64'd1);
    expectRec(1'b1, 5'd7, 64'd7, 1'b1, 64'h20);
    expectRec(1'b1, 5'd8, 64'd8, 1'b1, 64'h24);
    tick();
    in_valid = '0;
    checkRetire(2);
    tick();
    checkRetire(2);

    // JAL redirects and squashes the ADD in its own group
    $display("[TB] step 3: JAL redirect");
    eA        = mkAlu(64'h100, 5'd1, 64'h201);
    eA.isJump = 1'b1;
    eA.isWriteBack = 1'b0;
    applyStimulus(2'b11, eA, mkAlu(64'h104, 5'd3, 64'h33));
    expectRec(1'b1, 5'd1, 64'h104, 1'b1, 64'h100);
    tick();
    in_valid = '0;
    checkRetire(0);
    tick();
    checkRetire(1);
    checkOutput("jal.redirectEn", 64'(redirect_en), 64'd1);
    checkOutput("jal.redirectAddr", redirect_addr, 64'h200);
    tick();
    checkRetire(0);
    checkOutput("jal.pulseEnds", 64'(redirect_en), 64'd0);

    // Taken branch with two younger queued entries
    $display("[TB] step 4: taken branch squash");
    commit_ready = 1'b0;
    applyStimulus(2'b11, mkBranch(64'h200, 64'h300), mkAlu(64'h204, 5'd10, 64'd10));
    expectRec(1'b0, 5'd0, 64'h300, 1'b0, 64'h200);
    tick();
    applyStimulus(2'b01, mkAlu(64'h208, 5'd11, 64'd11), '0);
    tick();
    checkOutput("br.fullReady", 64'(in_ready), 64'd0);
    applyStimulus(2'b11, mkAlu(64'h20c, 5'd13, 64'd13), mkAlu(64'h210, 5'd14, 64'd14));
    commit_ready = 1'b1;
    tick();
    in_valid = '0;
    checkRetire(1);
    checkOutput("br.redirectAddr", redirect_addr, 64'h300);
    tick();
    checkRetire(0);
    checkOutput("br.emptyReady", 64'(in_ready), 64'd1);

    // Group arriving on the redirect edge while there is room is dropped
    commit_ready = 1'b0;
    applyStimulus(2'b11, mkBranch(64'h300, 64'h401), mkAlu(64'h304, 5'd15, 64'd15));
    expectRec(1'b0, 5'd0, 64'h401, 1'b0, 64'h300);
    tick();
    checkOutput("br2.ready", 64'(in_ready), 64'd1);
    applyStimulus(2'b11, mkAlu(64'h308, 5'd16, 64'd16), mkAlu(64'h30c, 5'd17, 64'd17));
    commit_ready = 1'b1;
    tick();
    in_valid = '0;
    checkRetire(1);
    checkOutput("br2.redirectAddr", redirect_addr, 64'h400);
    tick();
    checkRetire(0);
    applyStimulus(2'b11, mkAlu(64'h400, 5'd18, 64'd18), mkAlu(64'h404, 5'd19, 64'd19));
    expectRec(1'b1, 5'd18, 64'd18, 1'b1, 64'h400);
    expectRec(1'b1, 5'd19, 64'd19, 1'b1, 64'h404);
    tick();
    in_valid = '0;
    checkRetire(0);
    tick();
    checkRetire(2);

    // Write to x0 retires without a regfile write, then reset mid-stream
    $display("[TB] step 5: x0 write and mid-stream reset");
    applyStimulus(2'b01, mkAlu(64'h500, 5'd0, 64'hDEAD), '0);
    expectRec(1'b0, 5'd0, 64'hDEAD, 1'b0, 64'h500);
    tick();
    in_valid = '0;
    checkRetire(0);
    tick();
    checkRetire(1);
    commit_ready = 1'b0;
    applyStimulus(2'b11, mkAlu(64'h600, 5'd20, 64'd20), mkAlu(64'h604, 5'd21, 64'd21));
    tick();
    in_valid = '0;
    rst      = 1'b1;
    tick();
    expInstret = '0;
    checkOutput("rst2.inReady", 64'(in_ready), 64'd1);
    checkOutput("rst2.redirectEn", 64'(redirect_en), 64'd0);
    checkRetire(0);
    rst          = 1'b0;
    commit_ready = 1'b1;
    tick();
    checkRetire(0);

`ifdef WB_FWD_EN
    // Bypass lookup returns the youngest queued writer
    $display("[TB] step 6: forwarding lookup");
    commit_ready = 1'b0;
    applyStimulus(2'b11, mkAlu(64'h700, 5'd5, 64'd1), mkAlu(64'h704, 5'd5, 64'd9));
    expectRec(1'b1, 5'd5, 64'd1, 1'b1, 64'h700);
    expectRec(1'b1, 5'd5, 64'd9, 1'b1, 64'h704);
    tick();
    in_valid  = '0;
    fwd_rs[0] = 5'd5;
    fwd_rs[1] = 5'd0;
    #1;
    checkOutput("fwd.hit0", 64'(fwd_hit[0]), 64'd1);
    checkOutput("fwd.data0", fwd_data[0], 64'd9);
    checkOutput("fwd.hitX0", 64'(fwd_hit[1]), 64'd0);
    fwd_rs       = '0;
    commit_ready = 1'b1;
    tick();
    checkRetire(2);
`endif

    checkOutput("sbEmpty", 64'(expQ.size()), 64'd0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
